// File: rtl/spi_flash_responder_if.sv
// Pin and memory-port bundle for spi_flash_responder.
// The slave modport is the responder; the master modport is the
// surrounding environment (SPI host pads plus the backing memory).
interface spi_flash_responder_if #(
    parameter int ADDR_WIDTH = 20
);
    logic                  spi_sck_i;
    logic                  spi_csb_i;
    logic                  spi_sd_i;
    logic                  spi_sd_o;
    logic                  spi_sd_oe_o;
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [7:0]            mem_rdata_i;
    logic                  mem_we_o;
    logic [7:0]            mem_wdata_o;

    modport slave (
        input  spi_sck_i, spi_csb_i, spi_sd_i, mem_rdata_i,
        output spi_sd_o, spi_sd_oe_o, mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o
    );

    modport master (
        output spi_sck_i, spi_csb_i, spi_sd_i, mem_rdata_i,
        input  spi_sd_o, spi_sd_oe_o, mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o
    );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI NOR flash emulator (mode 0, single bit). SCK/CSB/MOSI are oversampled
// on clk_i; READ, FAST READ, RDSR and RDID are served, read data comes from
// an external byte-wide memory with one cycle of read latency.
// Optional macro SPI_FLASH_RESP_PROGRAM_EN adds WREN, WRDI and PAGE PROGRAM.
module spi_flash_responder #(
    parameter int          ADDR_WIDTH   = 20,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4018,
    parameter int          DUMMY_CYCLES = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    spi_flash_responder_if.slave   bus
);
    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_RDSR      = 8'h05;
    localparam logic [7:0] OP_RDID      = 8'h9F;
`ifdef SPI_FLASH_RESP_PROGRAM_EN
    localparam logic [7:0] OP_WREN      = 8'h06;
    localparam logic [7:0] OP_WRDI      = 8'h04;
    localparam logic [7:0] OP_PP        = 8'h02;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA_OUT, IGNORE, DATA_IN} state_t;
`else
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA_OUT, IGNORE} state_t;
`endif
    typedef enum logic [1:0] {SRC_MEM, SRC_STAT, SRC_ID} src_t;

    // Bit positions in the synchroniser vectors
    localparam int P_SCK  = 2;
    localparam int P_CSB  = 1;
    localparam int P_MOSI = 0;

    logic [2:0]            r_meta, r_sync;
    logic [2:1]            r_prev;
    state_t                r_state;
    src_t                  r_src;
    logic [7:0]            r_bit_cnt;
    logic [23:0]           r_shift;
    logic [7:0]            r_opcode;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_req;
    logic                  r_rd_pend;
    logic                  r_first;
    logic [7:0]            r_tx_shift;
    logic [3:0]            r_tx_cnt;
    logic [7:0]            r_stage;
    logic                  r_id_done;
    logic                  r_sd_o;
    logic                  r_oe;

    logic                  w_sck_rise, w_sck_fall, w_csb_fall, w_csb_rise;
    logic [23:0]           w_shift_next;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic                  w_wel;
    logic [7:0]            w_status;

    assign w_sck_rise   =  r_sync[P_SCK] & ~r_prev[P_SCK];
    assign w_sck_fall   = ~r_sync[P_SCK] &  r_prev[P_SCK];
    assign w_csb_fall   = ~r_sync[P_CSB] &  r_prev[P_CSB];
    assign w_csb_rise   =  r_sync[P_CSB] & ~r_prev[P_CSB];
    assign w_shift_next = {r_shift[22:0], r_sync[P_MOSI]};
    assign w_addr_inc   = r_addr + 1'b1;
    assign w_status     = {6'b0, w_wel, 1'b0};   // WIP is never set

`ifdef SPI_FLASH_RESP_PROGRAM_EN
    logic       r_wel;
    logic       r_pp_active;
    logic       r_mem_we;
    logic [7:0] r_mem_wdata;
    assign w_wel           = r_wel;
    assign bus.mem_we_o    = r_mem_we;
    assign bus.mem_wdata_o = r_mem_wdata;
`else
    assign w_wel           = 1'b0;
    assign bus.mem_we_o    = 1'b0;
    assign bus.mem_wdata_o = 8'h00;
`endif

    assign bus.spi_sd_o    = r_sd_o;
    assign bus.spi_sd_oe_o = r_oe;
    assign bus.mem_req_o   = r_mem_req;
    assign bus.mem_addr_o  = r_mem_addr;

    // Two-flop synchronisers plus edge-detect history (CSB idles high)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= 3'b010;
            r_sync <= 3'b010;
            r_prev <= 2'b01;
        end else begin
            r_meta <= {bus.spi_sck_i, bus.spi_csb_i, bus.spi_sd_i};
            r_sync <= r_meta;
            r_prev <= r_sync[2:1];
        end
    end

    // Command FSM with shift registers, prefetch and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_src      <= SRC_MEM;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_opcode   <= '0;
            r_addr     <= '0;
            r_mem_addr <= '0;
            r_mem_req  <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_first    <= 1'b0;
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
            r_stage    <= '0;
            r_id_done  <= 1'b0;
            r_sd_o     <= 1'b0;
            r_oe       <= 1'b0;
`ifdef SPI_FLASH_RESP_PROGRAM_EN
            r_wel       <= 1'b0;
            r_pp_active <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
`endif
        end else begin
            r_mem_req <= 1'b0;
`ifdef SPI_FLASH_RESP_PROGRAM_EN
            r_mem_we  <= 1'b0;
`endif
            // Only reads issued while serving data return a byte we use
            r_rd_pend <= r_mem_req && (r_state == DATA_OUT);
            r_oe      <= (r_state == DATA_OUT) && !r_sync[P_CSB];

            if (w_csb_rise) begin
                // Deselect aborts everything; partial bytes are dropped
                r_state <= IDLE;
                r_oe    <= 1'b0;
                r_sd_o  <= 1'b0;
`ifdef SPI_FLASH_RESP_PROGRAM_EN
                if (r_pp_active) r_wel <= 1'b0;
                r_pp_active <= 1'b0;
`endif
            end else begin
                case (r_state)
                    IDLE: if (w_csb_fall) begin
                        r_state   <= CMD;
                        r_bit_cnt <= 8'd0;
                        // An SCK rise coincident with select is command bit 7
                        if (w_sck_rise) begin
                            r_shift   <= w_shift_next;
                            r_bit_cnt <= 8'd1;
                        end
                    end

                    CMD: if (w_sck_rise) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                        if (r_bit_cnt == 8'd7) begin
                            r_bit_cnt <= 8'd0;
                            r_opcode  <= w_shift_next[7:0];
                            r_first   <= 1'b0;
                            r_tx_cnt  <= 4'd0;
                            r_id_done <= 1'b0;
                            case (w_shift_next[7:0])
                                OP_READ, OP_FAST_READ: r_state <= ADDR;
                                OP_RDSR: begin
                                    r_state    <= DATA_OUT;
                                    r_src      <= SRC_STAT;
                                    r_tx_shift <= w_status;
                                    r_stage    <= w_status;
                                end
                                OP_RDID: begin
                                    r_state    <= DATA_OUT;
                                    r_src      <= SRC_ID;
                                    r_tx_shift <= JEDEC_ID[23:16];
                                    r_stage    <= JEDEC_ID[15:8];
                                end
`ifdef SPI_FLASH_RESP_PROGRAM_EN
                                OP_WREN: begin r_wel <= 1'b1; r_state <= IGNORE; end
                                OP_WRDI: begin r_wel <= 1'b0; r_state <= IGNORE; end
                                OP_PP:   r_state <= r_wel ? ADDR : IGNORE;
`endif
                                // 0xAB (release power-down) and unknown opcodes
                                default: r_state <= IGNORE;
                            endcase
                        end
                    end

                    ADDR: if (w_sck_rise) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                        if (r_bit_cnt == 8'd23) begin
                            r_bit_cnt <= 8'd0;
                            r_addr    <= w_shift_next[ADDR_WIDTH-1:0];
                            if (r_opcode == OP_FAST_READ && DUMMY_CYCLES != 0) begin
                                r_state <= DUMMY;
`ifdef SPI_FLASH_RESP_PROGRAM_EN
                            end else if (r_opcode == OP_PP) begin
                                r_state     <= DATA_IN;
                                r_pp_active <= 1'b1;
`endif
                            end else begin
                                r_state    <= DATA_OUT;
                                r_src      <= SRC_MEM;
                                r_first    <= 1'b1;
                                r_mem_req  <= 1'b1;
                                r_mem_addr <= w_shift_next[ADDR_WIDTH-1:0];
                            end
                        end
                    end

                    DUMMY: if (w_sck_rise) begin
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                        if (r_bit_cnt == 8'(DUMMY_CYCLES - 1)) begin
                            r_state    <= DATA_OUT;
                            r_src      <= SRC_MEM;
                            r_first    <= 1'b1;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_addr;
                        end
                    end

                    DATA_OUT: begin
                        // First byte goes straight to the shifter, later ones to staging
                        if (r_rd_pend) begin
                            if (r_first) begin
                                r_tx_shift <= bus.mem_rdata_i;
                                r_tx_cnt   <= 4'd0;
                                r_first    <= 1'b0;
                                r_addr     <= w_addr_inc;
                                r_mem_addr <= w_addr_inc;
                                r_mem_req  <= 1'b1;
                            end else begin
                                r_stage <= bus.mem_rdata_i;
                            end
                        end
                        if (w_sck_fall && !r_first) begin
                            if (r_tx_cnt == 4'd8) begin
                                // Byte boundary: move staged byte in and refill staging
                                r_sd_o     <= r_stage[7];
                                r_tx_shift <= {r_stage[6:0], 1'b0};
                                r_tx_cnt   <= 4'd1;
                                case (r_src)
                                    SRC_MEM: begin
                                        r_addr     <= w_addr_inc;
                                        r_mem_addr <= w_addr_inc;
                                        r_mem_req  <= 1'b1;
                                    end
                                    SRC_STAT: r_stage <= w_status;
                                    default: begin
                                        r_stage   <= r_id_done ? 8'h00 : JEDEC_ID[7:0];
                                        r_id_done <= 1'b1;
                                    end
                                endcase
                            end else begin
                                r_sd_o     <= r_tx_shift[7];
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                                r_tx_cnt   <= r_tx_cnt + 4'd1;
                            end
                        end
                    end

`ifdef SPI_FLASH_RESP_PROGRAM_EN
                    DATA_IN: if (w_sck_rise) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                        if (r_bit_cnt == 8'd7) begin
                            r_bit_cnt   <= 8'd0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= w_shift_next[7:0];
                            r_mem_addr  <= r_addr;
                            // Increment wraps inside the 256-byte page
                            r_addr <= (r_addr & ~ADDR_WIDTH'(8'hFF)) |
                                      ADDR_WIDTH'(r_addr[7:0] + 8'd1);
                        end
                    end
`endif

                    default: ;   // IGNORE: wait for deselect
                endcase
            end
        end
    end
endmodule
